// File: rtl/fft_job_arbiter_if.sv
// fft_job_arbiter_if: bundles the two DMA channel streams, the wrapper dma2buf/buf2dma port and status.
//   req0/1_*  : channel input words (valid/ready/data)
//   rsp0/1_*  : result words back to channels (valid/ready/data)
//   dma2buf_* : write strobe + data into the wrapper input FIFO
//   buf2dma_* : read strobe out, data back one cycle later
//   dev_ready, dev_busy : wrapper status
//   owner, active, err_timeout, frames_done : arbiter status
// master = arbiter side, slave = channels + wrapper side.
interface fft_job_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] dma2buf_data;
  logic        dma2buf_data_valid;
  logic        buf2dma_data_rd;
  logic [31:0] buf2dma_data;
  logic        dev_ready, dev_busy;
  logic        owner, active, err_timeout;
  logic [15:0] frames_done;
  modport master (
    input  req0_valid, req1_valid, req0_data, req1_data, rsp0_ready, rsp1_ready,
           buf2dma_data, dev_ready, dev_busy,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           dma2buf_data, dma2buf_data_valid, buf2dma_data_rd,
           owner, active, err_timeout, frames_done
  );
  modport slave (
    output req0_valid, req1_valid, req0_data, req1_data, rsp0_ready, rsp1_ready,
           buf2dma_data, dev_ready, dev_busy,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
           dma2buf_data, dma2buf_data_valid, buf2dma_data_rd,
           owner, active, err_timeout, frames_done
  );
endinterface

// File: rtl/fft_job_arbiter.sv
// fft_job_arbiter: round-robin frame arbiter sharing one FFT wrapper between two DMA channels.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fft_job_arbiter_if.master (channel streams, wrapper port, status)
module fft_job_arbiter #(
  parameter int FRAME_WORDS    = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rst_n,
  fft_job_arbiter_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, DRAIN = 2'd3;
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    state;
  logic          owner, last_owner;
  logic [CW-1:0] in_cnt, out_cnt, rd_cnt;
  logic [WW-1:0] wait_cnt;
  logic          rd_pend, rsp_valid, err;
  logic [31:0]   rsp_data;
  logic [15:0]   frames_done;
  logic          own_valid, own_rsp_ready, beat, rd_go, hs, exit_wait, grant;
  logic [31:0]   own_data;
  always_comb begin
    own_valid     = owner ? bus.req1_valid : bus.req0_valid;
    own_data      = owner ? bus.req1_data : bus.req0_data;
    own_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;
    beat          = state == LOAD && own_valid && bus.dev_ready && in_cnt < CW'(FRAME_WORDS);
    // single outstanding read; the response slot must be free or freeing this cycle
    rd_go         = state == DRAIN && !rd_pend && rd_cnt < CW'(FRAME_WORDS) && (!rsp_valid || own_rsp_ready);
    hs            = state == DRAIN && rsp_valid && own_rsp_ready;
    // output FIFO full: wrapper neither busy nor accepting input
    exit_wait     = !bus.dev_busy && !bus.dev_ready;
    grant         = (bus.req0_valid ^ bus.req1_valid) ? bus.req1_valid : !last_owner;
  end
  assign bus.req0_ready         = beat && !owner;
  assign bus.req1_ready         = beat && owner;
  assign bus.dma2buf_data_valid = beat;
  assign bus.dma2buf_data       = state == LOAD ? own_data : '0;
  assign bus.buf2dma_data_rd    = rd_go;
  assign bus.rsp0_valid         = rsp_valid && !owner;
  assign bus.rsp1_valid         = rsp_valid && owner;
  assign bus.rsp0_data          = rsp_data;
  assign bus.rsp1_data          = rsp_data;
  assign bus.owner              = owner;
  assign bus.active             = state != IDLE;
  assign bus.err_timeout        = err;
  assign bus.frames_done        = frames_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      in_cnt      <= '0;
      out_cnt     <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      rd_pend     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      err         <= 1'b0;
      frames_done <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (bus.req0_valid || bus.req1_valid) begin
          owner  <= grant;
          in_cnt <= '0;
          state  <= LOAD;
        end
        LOAD: if (beat) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == CW'(FRAME_WORDS - 1)) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          // exit has priority over a coincident timeout
          if (exit_wait) begin
            state   <= DRAIN;
            rd_cnt  <= '0;
            out_cnt <= '0;
            rd_pend <= 1'b0;
          end else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          rd_pend <= rd_go;
          if (rd_go) rd_cnt <= rd_cnt + 1'b1;
          // wrapper data is valid the cycle after the read strobe
          if (rd_pend) begin
            rsp_data  <= bus.buf2dma_data;
            rsp_valid <= 1'b1;
          end else if (hs) begin
            rsp_valid <= 1'b0;
          end
          if (hs) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == CW'(FRAME_WORDS - 1)) begin
              state       <= IDLE;
              last_owner  <= owner;
              frames_done <= frames_done + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/fft_job_arbiter.md
# fft_job_arbiter

Frame-level arbiter and sequencer for the FFT accelerator wrapper. Shares one FFT wrapper between two DMA requester channels. Each frame of FRAME_WORDS input words is granted to one channel in round-robin order and pushed into the wrapper. The block then waits for the transform to complete and drains exactly FRAME_WORDS result words back to the owning channel. It sits between the two DMA stream ports and the wrapper's dma2buf/buf2dma interface.

## Interface
Parameters:
- FRAME_WORDS, 32 — words per frame in and out; must equal the wrapper FIFO depth.
- TIMEOUT_CYCLES, 4096 — maximum cycles in WAIT before abort.

Ports:
- clk  in  1  — single clock; all logic on rising edge.
- rst  in  1  — asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  — channel input word valid.
- req0_data / req1_data  in  32  — channel input word, packed {X3,X2,X1,X0}.
- req0_ready / req1_ready  out  1  — channel input word accepted.
- rsp0_valid / rsp1_valid  out  1  — result word valid to channel.
- rsp0_data / rsp1_data  out  32  — result word, packed {Y3,Y2,Y1,Y0}.
- rsp0_ready / rsp1_ready  in  1  — channel accepts result word.
- dma2buf_data  out  32  — word to the wrapper input FIFO.
- dma2buf_data_valid  out  1  — write strobe to the wrapper.
- buf2dma_data_rd  out  1  — read strobe to the wrapper output FIFO.
- buf2dma_data  in  32  — wrapper output FIFO data; valid 1 cycle after rd.
- dev_ready  in  1  — wrapper can accept input.
- dev_busy  in  1  — wrapper is filling, computing or loading output.
- owner  out  1  — channel holding the current grant.
- active  out  1  — FSM is not in IDLE.
- err_timeout  out  1  — one-cycle pulse on WAIT timeout.
- frames_done  out  16  — count of completed frames; wraps at 65535 -> 0.

## Operation
- FSM has four states: IDLE, LOAD, WAIT, DRAIN. Counters: in_cnt, out_cnt and wait_cnt. Also holds a last_owner register.
- **IDLE:**
  - If exactly one reqN_valid is high, grant channel N.
  - If both are high, grant !last_owner.
  - On a grant: set owner, clear in_cnt, go to LOAD.
  - No ready is asserted in IDLE.
- **LOAD:**
  - Beat = req[owner]_valid & dev_ready & (in_cnt < FRAME_WORDS).
  - req[owner]_ready and dma2buf_data_valid both equal beat.
  - dma2buf_data = req[owner]_data (combinational pass-through).
  - in_cnt increments on each beat.
  - When in_cnt reaches FRAME_WORDS, go to WAIT and clear wait_cnt.
  - The non-owner ready stays 0.
- **WAIT:**
  - Leave for DRAIN when !dev_busy & !dev_ready, i.e. the wrapper output FIFO is full.
  - wait_cnt increments every cycle.
  - If wait_cnt reaches TIMEOUT_CYCLES-1 without the exit condition:
    - pulse err_timeout;
    - go to IDLE;
    - do not update last_owner or frames_done.
- **DRAIN:**
  - Assert buf2dma_data_rd for one cycle when all of these hold:
    - no read is in flight;
    - rd_issued < FRAME_WORDS;
    - !rsp[owner]_valid, or rsp[owner]_ready is high in that cycle.
  - On the following cycle, capture buf2dma_data into the response register and set rsp[owner]_valid.
  - rsp valid/data are held until ready; out_cnt increments on each rsp handshake.
  - When out_cnt reaches FRAME_WORDS (final handshake):
    - go to IDLE;
    - last_owner <= owner;
    - frames_done increments.
- Non-owner rsp valid is always 0. Both rsp data outputs share one register; only the owner's valid qualifies it.

## Timing
- Reset values: all readies, valids, rd strobes, err_timeout, active and counters are 0. Data outputs are 0, owner = 0, and last_owner = 1, so channel 0 wins the first contention.
- Reset is asynchronous and mid-frame. Every state returns to IDLE immediately and no further strobes are issued. Recovering the wrapper's own state is the system's responsibility.
- Grant latency: a request in IDLE at cycle t produces the first possible ready at cycle t+1.
- LOAD throughput: one word per cycle. Gaps on req_valid or dev_ready stall without losing count.
- DRAIN throughput: one word per 2 cycles at most, because reads are single-outstanding.
- A new frame can be granted on the cycle after the final rsp handshake.
- Requests from the non-owner during a frame are ignored until IDLE. No ready is ever issued to them.
- Simultaneous events:
  - In WAIT, the exit condition and the timeout in the same cycle resolve as exit (DRAIN wins).
  - A final handshake in DRAIN plus new requests takes one IDLE cycle before the grant.

## Test plan
- Single ch0 frame, words 0..31, no stalls:
  - 32 dma2buf strobes in 32 consecutive cycles after grant;
  - ch0 receives 32 results in order;
  - frames_done=1, owner=0; rsp1_valid never high.
- Both channels valid continuously for 4 frames:
  - grants alternate 0,1,0,1;
  - frames_done=4;
  - no beats accepted from the non-owner.
- Backpressure: ch0 rsp_ready high 1 cycle in 5 during DRAIN:
  - exactly 32 rd strobes;
  - data held stable while valid & !ready;
  - no word lost or duplicated.
- Timeout: model the wrapper holding dev_busy=1 forever, TIMEOUT_CYCLES=16:
  - err_timeout pulses once, 16 cycles after entering WAIT;
  - FSM returns to IDLE; frames_done unchanged.
- Reset asserted after 10 LOAD beats:
  - all outputs 0 asynchronously;
  - after release, a new ch1 frame completes normally with 32 beats.
- dev_ready toggling every other cycle in LOAD:
  - dma2buf_data_valid only while dev_ready=1;
  - exactly 32 beats; in_cnt never exceeds 32.
